// File: rtl/exe_cc_unit.sv
// exe_cc_unit: condition-code register, branch/cmov condition evaluation and
// the execute-to-memory pipeline register of a Y86-64 style pipeline.
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   alu_fun, alu_a/b     ALU operation and operands in execute
//   val_e                ALU result for those operands
//   e_valid, set_cc      execute holds a real instruction / an OPq
//   suppress             a later stage holds an exception; blocks CC update
//   ifun                 condition selector
//   is_cmov, e_dst_e     conditional move marker and its destination
//   m_stall, m_bubble    control for the execute-to-memory register
//   cc                   registered flags {ZF,SF,OF}
//   e_cnd                condition result evaluated on the registered flags
//   M_valE/M_dstE/M_cnd/M_valid  memory-stage register contents
module exe_cc_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  alu_fun,
    input  logic [63:0] alu_a,
    input  logic [63:0] alu_b,
    input  logic [63:0] val_e,
    input  logic        e_valid,
    input  logic        set_cc,
    input  logic        suppress,
    input  logic [3:0]  ifun,
    input  logic        is_cmov,
    input  logic [3:0]  e_dst_e,
    input  logic        m_stall,
    input  logic        m_bubble,
    output logic [2:0]  cc,
    output logic        e_cnd,
    output logic [63:0] M_valE,
    output logic [3:0]  M_dstE,
    output logic        M_cnd,
    output logic        M_valid
);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [3:0] RNONE   = 4'hF;

    // Condition evaluation on {ZF,SF,OF}; unused selectors never fire.
    function automatic logic cond_eval(input logic [3:0] sel, input logic [2:0] flags);
        logic zf;
        logic lt;
        zf = flags[2];
        lt = flags[1] ^ flags[0];
        case (sel)
            4'd0:    cond_eval = 1'b1;
            4'd1:    cond_eval = lt | zf;
            4'd2:    cond_eval = lt;
            4'd3:    cond_eval = zf;
            4'd4:    cond_eval = ~zf;
            4'd5:    cond_eval = ~lt;
            4'd6:    cond_eval = ~lt & ~zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    logic [2:0]  cc_q;
    logic [2:0]  cc_d;
    logic        of_s;
    logic        cc_we_s;
    logic        cnd_s;
    logic [3:0]  dst_eff_s;
    logic [63:0] m_vale_q;
    logic [63:0] m_vale_d;
    logic [3:0]  m_dste_q;
    logic [3:0]  m_dste_d;
    logic        m_cnd_q;
    logic        m_cnd_d;
    logic        m_valid_q;
    logic        m_valid_d;

    // Signed overflow of the execute result; logical ops never overflow.
    always_comb begin
        of_s = 1'b0;
        case (alu_fun)
            ALU_ADD: of_s = (alu_a[63] == alu_b[63]) && (val_e[63] != alu_a[63]);
            ALU_SUB: of_s = (alu_a[63] != alu_b[63]) && (val_e[63] != alu_a[63]);
            default: of_s = 1'b0;
        endcase
    end

    // Next flags and their write enable; bubbles and excepting pipelines keep the old CC.
    always_comb begin
        cc_d    = {(val_e == 64'd0), val_e[63], of_s};
        cc_we_s = set_cc && e_valid && !suppress;
    end

    // Condition uses the flags already in cc_q, never the ones being written this edge.
    always_comb begin
        cnd_s = cond_eval(ifun, cc_q);
        if (is_cmov && !cnd_s) begin
            dst_eff_s = RNONE;
        end else begin
            dst_eff_s = e_dst_e;
        end
    end

    // Memory register next state: stall holds over bubble, bubble over normal load.
    always_comb begin
        m_vale_d  = m_vale_q;
        m_dste_d  = m_dste_q;
        m_cnd_d   = m_cnd_q;
        m_valid_d = m_valid_q;
        if (m_stall) begin
            m_vale_d  = m_vale_q;
            m_dste_d  = m_dste_q;
            m_cnd_d   = m_cnd_q;
            m_valid_d = m_valid_q;
        end else if (m_bubble) begin
            m_vale_d  = 64'd0;
            m_dste_d  = RNONE;
            m_cnd_d   = 1'b0;
            m_valid_d = 1'b0;
        end else begin
            m_vale_d  = val_e;
            m_dste_d  = dst_eff_s;
            m_cnd_d   = cnd_s;
            m_valid_d = e_valid;
        end
    end

    // Condition-code register; reset leaves ZF set so "equal" holds after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
        end else if (cc_we_s) begin
            cc_q <= cc_d;
        end else begin
            cc_q <= cc_q;
        end
    end

    // Execute-to-memory register; reset discards any in-flight instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_vale_q  <= 64'd0;
            m_dste_q  <= RNONE;
            m_cnd_q   <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            m_vale_q  <= m_vale_d;
            m_dste_q  <= m_dste_d;
            m_cnd_q   <= m_cnd_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign cc      = cc_q;
    assign e_cnd   = cnd_s;
    assign M_valE  = m_vale_q;
    assign M_dstE  = m_dste_q;
    assign M_cnd   = m_cnd_q;
    assign M_valid = m_valid_q;

endmodule

// File: tb/tb_exe_cc_unit.sv
module tb_exe_cc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  alu_fun;
    logic [63:0] alu_a, alu_b, val_e;
    logic        e_valid, set_cc, suppress, is_cmov, m_stall, m_bubble;
    logic [3:0]  ifun, e_dst_e;
    logic [2:0]  cc;
    logic        e_cnd;
    logic [63:0] M_valE;
    logic [3:0]  M_dstE;
    logic        M_cnd, M_valid;

    int checks = 0;
    int errors = 0;

    // Reference state: flags as separate booleans and the memory-stage record.
    bit          mz, ms, mo;
    logic [63:0] r_vale;
    logic [3:0]  r_dste;
    bit          r_cnd, r_valid;

    exe_cc_unit dut (
        .clk(clk), .rst_n(rst_n), .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b),
        .val_e(val_e), .e_valid(e_valid), .set_cc(set_cc), .suppress(suppress),
        .ifun(ifun), .is_cmov(is_cmov), .e_dst_e(e_dst_e), .m_stall(m_stall),
        .m_bubble(m_bubble), .cc(cc), .e_cnd(e_cnd), .M_valE(M_valE), .M_dstE(M_dstE),
        .M_cnd(M_cnd), .M_valid(M_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Condition meaning: "less" is a signed less-than, expressed as SF differing from OF.
    function automatic bit ref_cond(input logic [3:0] f);
        bit less;
        less = (ms != mo);
        case (f)
            4'd0:    return 1'b1;
            4'd1:    return less || mz;
            4'd2:    return less;
            4'd3:    return mz;
            4'd4:    return !mz;
            4'd5:    return !less;
            4'd6:    return !less && !mz;
            default: return 1'b0;
        endcase
    endfunction

    // True ALU result, used to keep val_e consistent with the operands.
    function automatic logic [63:0] alu_res(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        case (f)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Overflow as "the 65-bit signed result does not fit in 64 bits".
    function automatic bit ref_of(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] w;
        if (f == 2'b00) w = {a[63], a} + {b[63], b};
        else if (f == 2'b01) w = {a[63], a} - {b[63], b};
        else return 1'b0;
        return w[64] != w[63];
    endfunction

    // Advance the reference by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit c;
        c = ref_cond(ifun);
        if (!rst_n) begin
            mz = 1; ms = 0; mo = 0;
            r_vale = 64'd0; r_dste = 4'hF; r_cnd = 0; r_valid = 0;
        end else begin
            if (set_cc && e_valid && !suppress) begin
                mz = (val_e == 64'd0);
                ms = ($signed(val_e) < 0);
                mo = ref_of(alu_fun, alu_a, alu_b);
            end
            if (m_stall) begin
                // hold
            end else if (m_bubble) begin
                r_vale = 64'd0; r_dste = 4'hF; r_cnd = 0; r_valid = 0;
            end else begin
                r_vale  = val_e;
                r_dste  = (is_cmov && !c) ? 4'hF : e_dst_e;
                r_cnd   = c;
                r_valid = e_valid;
            end
        end
    endtask

    // One clock: update the reference at the edge, compare registered outputs at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("cc", {61'd0, cc}, {61'd0, mz, ms, mo});
        chk("M_valE", M_valE, r_vale);
        chk("M_dstE", {60'd0, M_dstE}, {60'd0, r_dste});
        chk("M_cnd", {63'd0, M_cnd}, {63'd0, r_cnd});
        chk("M_valid", {63'd0, M_valid}, {63'd0, r_valid});
    endtask

    // Let combinational inputs settle and compare the condition output.
    task automatic settle();
        #1;
        chk("e_cnd", {63'd0, e_cnd}, {63'd0, ref_cond(ifun)});
    endtask

    task automatic idle();
        rst_n = 1; alu_fun = 2'b00; alu_a = 64'd0; alu_b = 64'd0; val_e = 64'd0;
        e_valid = 0; set_cc = 0; suppress = 0; ifun = 4'd0; is_cmov = 0;
        e_dst_e = 4'hF; m_stall = 0; m_bubble = 0;
    endtask

    task automatic op(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        alu_fun = f; alu_a = a; alu_b = b; val_e = alu_res(f, a, b);
        e_valid = 1; set_cc = 1;
    endtask

    initial begin
        idle();
        // Reset for one edge while stall and set_cc are active.
        rst_n = 0; m_stall = 1; set_cc = 1; e_valid = 1; val_e = 64'h77;
        tick();
        chk("rst_cc_lit", {61'd0, cc}, 64'd4);
        chk("rst_dst_lit", {60'd0, M_dstE}, 64'hF);
        chk("rst_valid_lit", {63'd0, M_valid}, 64'd0);
        idle(); ifun = 4'd3; settle();
        chk("rst_e_lit", {63'd0, e_cnd}, 64'd1);

        // Subtract of equal values sets ZF.
        op(2'b01, 64'h36, 64'h36); tick();
        chk("subeq_cc_lit", {61'd0, cc}, 64'd4);
        idle(); ifun = 4'd3; settle(); chk("subeq_e3_lit", {63'd0, e_cnd}, 64'd1);
        ifun = 4'd4; settle(); chk("subeq_e4_lit", {63'd0, e_cnd}, 64'd0);

        // Add overflow.
        op(2'b00, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000); tick();
        chk("addov_cc_lit", {61'd0, cc}, 64'd3);
        idle(); ifun = 4'd2; settle(); chk("addov_l_lit", {63'd0, e_cnd}, 64'd0);
        ifun = 4'd6; settle(); chk("addov_g_lit", {63'd0, e_cnd}, 64'd1);
        ifun = 4'd1; settle(); chk("addov_le_lit", {63'd0, e_cnd}, 64'd0);

        // Sub overflow, first suppressed, then allowed.
        op(2'b01, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000); suppress = 1; tick();
        chk("subov_supp_lit", {61'd0, cc}, 64'd3);
        suppress = 0; tick();
        chk("subov_cc_lit", {61'd0, cc}, 64'd1);

        // Invalid instruction with set_cc leaves cc alone.
        op(2'b01, 64'h5, 64'h5); e_valid = 0; tick();
        chk("bubble_setcc_lit", {61'd0, cc}, 64'd1);

        // Conditional move that fails, then one that succeeds.
        op(2'b01, 64'h9, 64'h9); tick();
        idle(); is_cmov = 1; ifun = 4'd4; e_dst_e = 4'd3; val_e = 64'h5; e_valid = 1; settle(); tick();
        chk("cmov_dst_lit", {60'd0, M_dstE}, 64'hF);
        chk("cmov_vale_lit", M_valE, 64'h5);
        chk("cmov_cnd_lit", {63'd0, M_cnd}, 64'd0);
        ifun = 4'd3; settle(); tick();
        chk("cmov_ok_lit", {60'd0, M_dstE}, 64'd3);

        // Stall beats bubble, then bubble alone clears.
        idle(); e_valid = 1; val_e = 64'h3C; e_dst_e = 4'd2; tick();
        val_e = 64'h8; m_stall = 1; m_bubble = 1; tick();
        chk("stall_vale_lit", M_valE, 64'h3C);
        m_stall = 0; tick();
        chk("bub_vale_lit", M_valE, 64'd0);
        chk("bub_dst_lit", {60'd0, M_dstE}, 64'hF);
        chk("bub_valid_lit", {63'd0, M_valid}, 64'd0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] a, b;
            logic [1:0]  f;
            f = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       begin a = 64'h4000_0000_0000_0000; b = 64'h4000_0000_0000_0000; end
                1:       begin a = 64'h8000_0000_0000_0000; b = {$urandom(), $urandom()}; end
                2:       begin a = {$urandom(), $urandom()}; b = a; end
                default: begin a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; end
            endcase
            rst_n    = ($urandom_range(0, 63) != 0);
            alu_fun  = f; alu_a = a; alu_b = b; val_e = alu_res(f, a, b);
            e_valid  = ($urandom_range(0, 3) != 0);
            set_cc   = $urandom_range(0, 1);
            suppress = ($urandom_range(0, 5) == 0);
            ifun     = 4'($urandom_range(0, 15));
            is_cmov  = $urandom_range(0, 1);
            e_dst_e  = 4'($urandom_range(0, 15));
            m_stall  = ($urandom_range(0, 5) == 0);
            m_bubble = ($urandom_range(0, 5) == 0);
            settle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
